// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seg7 display scanner.
// Optional feature macro used by seg7_scan: SEG7_LEADING_ZERO_BLANK_EN.
package seg7_pkg;

    localparam int MAX_DIGITS          = 8;
    localparam int DEFAULT_REFRESH_DIV = 100000;

    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    // Active-low anode pattern with only the selected digit driven.
    function automatic logic [MAX_DIGITS-1:0] anode_onehot_low(input logic [2:0] idx);
        return ~(MAX_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Bus between the display controller and the digit scanner.
interface seg7_scan_if
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = MAX_DIGITS
);

    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [3:0]              val;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;
    logic                    pending;

    modport master (
        output value, load, digit_en,
        input  val, an, frame_done, pending
    );

    modport slave (
        input  value, load, digit_en,
        output val, an, frame_done, pending
    );

endinterface

// File: rtl/seg7_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every REFRESH_DIV clocks.
module seg7_tick_gen
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] count;

    assign tick = (count == CW'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (tick)
            count <= '0;
        else
            count <= count + CW'(1);
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed hex digit scanner feeding a registered 7-segment decoder.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = MAX_DIGITS,
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);

    localparam int W     = 4 * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic                  tick;
    logic [IDX_W-1:0]      idx, idx_next;
    logic [W-1:0]          active, active_next;
    logic [W-1:0]          shadow, shadow_next;
    logic                  pending, pending_next;
    logic [3:0]            val, val_next;
    logic [NUM_DIGITS-1:0] an, an_next;
    logic                  running;
    logic                  last_idx, wrap;
    logic [NUM_DIGITS-1:0] lit;
    logic [MAX_DIGITS-1:0] an_sel;

    seg7_tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign last_idx = (idx == IDX_W'(NUM_DIGITS - 1));
    assign wrap     = tick && last_idx;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit stays lit if it or any more significant digit is non-zero.
    always_comb begin
        lit    = '0;
        lit[0] = 1'b1;
        for (int i = 1; i < NUM_DIGITS; i++)
            lit[i] = |(active >> (4 * i));
    end
`else
    assign lit = '1;
`endif

    // Loads landing on the wrap tick bypass the shadow so the new frame starts clean.
    always_comb begin
        idx_next     = idx;
        active_next  = active;
        shadow_next  = shadow;
        pending_next = pending;
        val_next     = val;
        an_sel       = anode_onehot_low(3'(idx));
        an_next      = '1;

        if (tick)
            idx_next = last_idx ? '0 : idx + IDX_W'(1);

        if (wrap) begin
            if (bus.load) begin
                active_next  = bus.value;
                shadow_next  = bus.value;
                pending_next = 1'b0;
            end else if (pending) begin
                active_next  = shadow;
                pending_next = 1'b0;
            end
        end else if (bus.load) begin
            shadow_next  = bus.value;
            pending_next = 1'b1;
        end

        if (tick)
            val_next = active_next[{idx_next, 2'b00} +: 4];

        if (running && bus.digit_en[idx] && lit[idx])
            an_next = an_sel[NUM_DIGITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            val     <= '0;
            an      <= '1;
            running <= 1'b0;
        end else begin
            idx     <= idx_next;
            active  <= active_next;
            shadow  <= shadow_next;
            pending <= pending_next;
            val     <= val_next;
            an      <= an_next;
            running <= running | tick;
        end
    end

    assign bus.val        = val;
    assign bus.an         = an;
    assign bus.pending    = pending;
    assign bus.frame_done = wrap;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized and directed bench for seg7_scan against a cycle-count based reference model.
module tb_seg7_scan;

    localparam int N  = 4;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seg7_scan_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: t counts clocks since reset, s counts slot ticks since reset.
    int          t = 0;
    int          s = 0;
    logic [15:0] m_active  = '0;
    logic [15:0] m_shadow  = '0;
    logic        m_pending = 1'b0;
    logic [3:0]  m_val     = '0;
    logic [3:0]  m_an      = 4'hF;
    logic [15:0] cur_value = '0;
    logic [3:0]  cur_en    = 4'hF;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic digit_lit(input int d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        return (d == 0) || ((m_active >> (4 * d)) != 16'h0);
`else
        return (d >= 0);
`endif
    endfunction

    function automatic logic next_edge_wraps();
        return ((t % RD) == RD - 1) && ((s % N) == N - 1);
    endfunction

    task automatic modelStep(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] en);
        int         cur;
        logic       tk, wr;
        logic [3:0] one;
        one = 4'b0001;
        if (r) begin
            t = 0; s = 0;
            m_active = '0; m_shadow = '0; m_pending = 1'b0;
            m_val = '0; m_an = 4'hF;
        end else begin
            cur  = s % N;
            m_an = (s > 0 && en[cur] && digit_lit(cur)) ? ~(one << cur) : 4'hF;
            tk   = ((t % RD) == RD - 1);
            wr   = tk && (cur == N - 1);
            if (tk) s++;
            if (wr && ld) begin
                m_active = v; m_shadow = v; m_pending = 1'b0;
            end else if (wr && m_pending) begin
                m_active = m_shadow; m_pending = 1'b0;
            end else if (!wr && ld) begin
                m_shadow = v; m_pending = 1'b1;
            end
            if (tk) m_val = m_active[4 * (s % N) +: 4];
            t++;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] en);
        rst          = r;
        bus.load     = ld;
        bus.value    = v;
        bus.digit_en = en;
        @(posedge clk);
        modelStep(r, ld, v, en);
        #1;
        checkOutput("val", 32'(bus.val), 32'(m_val));
        checkOutput("an", 32'(bus.an), 32'(m_an));
        checkOutput("pending", 32'(bus.pending), 32'(m_pending));
        checkOutput("frame_done", 32'(bus.frame_done), 32'(next_edge_wraps()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, cur_value, cur_en);
    endtask

    initial begin
        bus.load     = 1'b0;
        bus.value    = '0;
        bus.digit_en = 4'hF;

        applyStimulus(1'b1, 1'b0, 16'h0, 4'hF);
        applyStimulus(1'b1, 1'b0, 16'h0, 4'hF);
        checkOutput("reset_an", 32'(bus.an), 32'hF);
        checkOutput("reset_val", 32'(bus.val), 32'h0);

        cur_value = 16'h1234; cur_en = 4'hF;
        applyStimulus(1'b0, 1'b1, cur_value, cur_en);
        checkOutput("load_pending", 32'(bus.pending), 32'h1);
        idle(40);

        // Mid-frame load: current frame keeps old data until the next wrap.
        for (int i = 0; i < 64 && (s % N) != 1; i++) idle(1);
        cur_value = 16'hABCD;
        applyStimulus(1'b0, 1'b1, cur_value, cur_en);
        idle(36);

        for (int i = 0; i < 64 && !next_edge_wraps(); i++) idle(1);
        cur_value = 16'h00F0;
        applyStimulus(1'b0, 1'b1, cur_value, cur_en);
        checkOutput("wrapload_val", 32'(bus.val), 32'h0);
        checkOutput("wrapload_pending", 32'(bus.pending), 32'h0);
        idle(20);

        cur_value = 16'h5555; cur_en = 4'b0101;
        applyStimulus(1'b0, 1'b1, cur_value, cur_en);
        idle(40);

        cur_en = 4'hF;
        for (int i = 0; i < 64 && (s % N) != 2; i++) idle(1);
        idle(1);
        applyStimulus(1'b1, 1'b0, cur_value, cur_en);
        checkOutput("midrst_val", 32'(bus.val), 32'h0);
        checkOutput("midrst_an", 32'(bus.an), 32'hF);
        checkOutput("midrst_pending", 32'(bus.pending), 32'h0);
        idle(3);
        checkOutput("first_tick_val_hold", 32'(bus.val), 32'h0);

        cur_value = 16'h0040;
        applyStimulus(1'b0, 1'b1, cur_value, cur_en);
        idle(36);
        cur_value = 16'h0000;
        applyStimulus(1'b0, 1'b1, cur_value, cur_en);
        idle(36);

        for (int i = 0; i < 500; i++) begin
            logic r, ld;
            r         = ($urandom_range(0, 63) == 0);
            ld        = ($urandom_range(0, 5) == 0);
            cur_value = 16'($urandom);
            if ($urandom_range(0, 3) == 0) cur_value[15:8] = 8'h00;
            cur_en    = 4'($urandom);
            applyStimulus(r, ld, cur_value, cur_en);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed digit scanner sitting directly upstream of the 7-segment decoder on the board display path.
- Holds a multi-digit hex value and cycles through the digits at a fixed refresh rate.
- Presents one 4-bit nibble per scan slot on val and drives the matching active-low anode.
- Anodes are delayed one cycle so they align with the decoder's registered seg output.

Parameters:
- NUM_DIGITS, 8, number of physical digits scanned, 2..8.
- REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz gives 1 kHz per digit); minimum 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- value  in  4*NUM_DIGITS  hex value; digit i = value[4i+3:4i]; digit 0 is rightmost.
- load  in  1  one-cycle strobe; captures value into the shadow register.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 blanks that digit (anode held off). Sampled live.
- val  out  4  nibble to the downstream seg7 decoder.
- an  out  NUM_DIGITS  anode drive, active low, one-hot-low or all ones.
- frame_done  out  1  one-cycle pulse on the tick where the index wraps to digit 0.
- pending  out  1  high while a loaded value waits for the next frame boundary.

Behaviour:
- Reset values (one edge with rst=1):
  - prescaler=0, idx=0, active=0, shadow=0.
  - pending=0, val=0, an=all ones, frame_done=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1.
  - tick is asserted while prescaler==REFRESH_DIV-1; the prescaler wraps to 0 on that cycle.
  - Counter width: $clog2(REFRESH_DIV).
- Scan:
  - On tick: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
  - On the same edge: val <= nibble idx_next of the active register, where active_next is used when committing.
- Anode alignment:
  - an is registered one cycle after val changes: an_next = digit_en[idx] ? ~(1<<idx) : all ones.
  - an therefore changes on the same edge the decoder updates seg.
  - Between reset and the first tick, an stays all ones.
- Frame commit (tick with idx wrapping to 0):
  - frame_done=1 for that cycle.
  - If pending: active <= shadow, pending <= 0.
  - Committed data is visible starting with digit 0 of the new frame; there is no tearing inside a frame.
- load:
  - shadow <= value; pending <= 1.
  - load coincident with a commit tick: active <= value directly; pending stays 0; val uses the new value.
  - Back-to-back loads: last one wins; pending stays 1.
- digit_en only gates an; val still cycles through blanked digits, so scan timing is unchanged.
- rst mid-frame: all state returns to reset values on that edge; scanning restarts at digit 0 after REFRESH_DIV cycles.
- frame_done period = NUM_DIGITS*REFRESH_DIV cycles.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit i>0 is blanked (an off) when it and all higher digits of active are 0.
  - Digit 0 is never suppressed.
  - Suppression is ANDed with digit_en and uses the same one-cycle-delayed path as an.
- Undefined: only digit_en controls blanking; no extra logic is synthesized.

Decomposition:
- Shared package seg7_pkg:
  - MAX_DIGITS=8, ANODE_OFF constant, default REFRESH_DIV.
  - A function giving the one-hot-low anode for an index.
- One sub-module: seg7_tick_gen.
  - Parameterised by REFRESH_DIV; inputs clk and rst; output tick.
  - Reused by any future refresh-rate logic.

Test Plan:
All scenarios use NUM_DIGITS=4 and REFRESH_DIV=4.
- Reset, then load value=16'h1234 with digit_en=4'hF:
  - pending=1 until the first wrap.
  - After commit, val sequence per slot is 4,3,2,1.
  - an is 1110,1101,1011,0111, each lagging its val by exactly 1 cycle.
  - frame_done pulses every 16 cycles.
- Load 16'hABCD mid-frame while 16'h1234 is displayed:
  - Remaining digits of the current frame still show 1234 nibbles.
  - ABCD appears starting at digit 0 of the next frame; pending then falls to 0.
- load asserted on the exact wrap tick with value=16'h00F0:
  - val=0 on that edge; active=16'h00F0; pending stays 0.
- digit_en=4'b0101 with value 16'h5555:
  - an shows only 1110 and 1011; slots 1 and 3 give 1111.
  - val still steps through all 4 digits.
- rst pulsed during digit 2:
  - Next cycle val=0, an=1111, pending=0.
  - First tick arrives 4 cycles after rst deasserts.
- With SEG7_LEADING_ZERO_BLANK_EN defined, value=16'h0040:
  - Digits 3 and 2 are blanked; digits 1 and 0 are lit.
  - value=16'h0000 lights only digit 0.
